uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte requesters sharing one UART transmitter.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 8192, clk cycles allowed in WAIT before abort (timeout build only).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_req  input  NUM_REQ  per-requester level request, held until own o_ack.
REQ-006 SHALL have port i_data  input  8*NUM_REQ  byte k at bits [8k+7:8k] belongs to requester k.
REQ-007 SHALL have port i_tx_done  input  1  one-cycle done pulse from the UART transmitter.
REQ-008 SHALL have port o_tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-009 SHALL have port o_tx_data  output  8  byte to transmit, stable from o_tx_start until ACK.
REQ-010 SHALL have port o_ack  output  NUM_REQ  one-hot, one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port o_grant_id  output  clog2(NUM_REQ)  index of current/last granted requester.
REQ-012 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port o_timeout  output  1  one-cycle abort pulse; constant 0 when timeout is compiled out.

Function
REQ-014 SHALL implement FSM states IDLE, LAUNCH, WAIT, ACK.
REQ-015 IDLE with any i_req bit high SHALL select a winner round-robin, searching from last_grant+1 upward with wrap, latch its byte into o_tx_data and its index into o_grant_id, and enter LAUNCH next cycle.
REQ-016 LAUNCH SHALL assert o_tx_start for exactly one cycle, then enter WAIT.
REQ-017 WAIT SHALL hold until i_tx_done sampled high, then enter ACK.
REQ-018 ACK SHALL pulse o_ack[o_grant_id] for one cycle, set last_grant = o_grant_id, and return to IDLE.
REQ-019 Latency: request sampled in IDLE at cycle N -> o_tx_start at N+1; i_tx_done at cycle M -> o_ack at M+1.
REQ-020 Back-to-back transfers SHALL be separated by at least one IDLE cycle; two requests can never be granted in one cycle.
REQ-021 i_tx_done outside WAIT (including coincident with o_tx_start) SHALL be ignored.
REQ-022 Deassertion of the granted i_req or change of i_data after grant SHALL NOT affect o_tx_data; the transfer completes and o_ack still pulses.
REQ-023 Simultaneous requests SHALL be served in rotating order; no requester waits more than NUM_REQ-1 grants.
REQ-024 o_tx_data and o_grant_id SHALL retain their last values in IDLE.

Reset
REQ-025 reset high SHALL immediately force IDLE, o_tx_start=0, o_ack=0, o_timeout=0, o_busy=0, o_tx_data=8'h00, o_grant_id=0, and last_grant=NUM_REQ-1 (requester 0 wins first).
REQ-026 reset asserted mid-transfer SHALL abandon it without o_ack.

Configuration
REQ-027 Macro UART_TX_SCHED_TIMEOUT_EN defined: a WAIT-cycle counter SHALL clear on WAIT entry; at count TIMEOUT_CYCLES-1 without i_tx_done, FSM SHALL enter ACK, pulsing o_timeout together with o_ack.
REQ-028 Macro undefined: no counter is built, WAIT is unbounded, o_timeout is tied 0.

Structure
REQ-029 Shared package uart_pkg SHALL hold the FSM state encoding and default NUM_REQ/TIMEOUT_CYCLES constants.
REQ-030 Round-robin selection SHALL be a sub-module uart_rr_arb (inputs req vector and last_grant; outputs valid and winner index; combinational).

Verification
REQ-031 Single request: i_req=4'b0001, byte 8'hA5, done 20 cycles after start -> o_tx_start one cycle after request, o_tx_data=8'hA5, o_ack=4'b0001 one cycle after done.
REQ-032 All request: i_req=4'b1111 held, re-raised after each ack -> grant order 0,1,2,3,0.
REQ-033 Withdraw: requester 2 drops i_req while in WAIT -> transfer finishes, o_ack=4'b0100 still pulses, o_tx_data unchanged.
REQ-034 Spurious done: i_tx_done pulsed in IDLE and in the LAUNCH cycle -> no o_ack, FSM stays in WAIT until a later done.
REQ-035 Timeout (macro on, TIMEOUT_CYCLES=16): no i_tx_done -> o_timeout and o_ack pulse together 16 cycles after WAIT entry; macro off -> FSM stays in WAIT indefinitely.
REQ-036 Reset in WAIT: reset pulse -> all outputs at reset values asynchronously; next i_req=4'b1000 with 4'b0001 also high -> requester 0 granted first.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encoding and default sizing for the UART transmit scheduler
package uart_pkg;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_TIMEOUT_CYCLES = 8192;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    // Index width for a requester id; a single requester still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// rtl/uart_rr_arb.sv - combinational round-robin pick starting after the last grant
module uart_rr_arb
    import uart_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDW     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_last_grant,
    output logic               o_valid,
    output logic [IDW-1:0]     o_winner
);

    // Walk last_grant+1, +2, ... with wrap; the first pending requester wins.
    always_comb begin
        int idx;
        o_valid  = 1'b0;
        o_winner = '0;
        idx      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(i_last_grant) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!o_valid && i_req[idx[IDW-1:0]]) begin
                o_valid  = 1'b1;
                o_winner = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin byte scheduler for one UART transmitter (optional WAIT timeout: UART_TX_SCHED_TIMEOUT_EN)
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter  int NUM_REQ        = DEF_NUM_REQ,
    parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int IDW            = id_width(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [8*NUM_REQ-1:0] i_data,
    input  logic                 i_tx_done,
    output logic                 o_tx_start,
    output logic [7:0]           o_tx_data,
    output logic [NUM_REQ-1:0]   o_ack,
    output logic [IDW-1:0]       o_grant_id,
    output logic                 o_busy,
    output logic                 o_timeout
);

    state_t           r_state;
    state_t           w_next;
    logic             w_valid;
    logic [IDW-1:0]   w_winner;
    logic [7:0]       w_sel_data;
    logic [7:0]       r_tx_data;
    logic [IDW-1:0]   r_grant_id;
    logic [IDW-1:0]   r_last_grant;
    logic             w_expire;

    uart_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req        (i_req),
        .i_last_grant (r_last_grant),
        .o_valid      (w_valid),
        .o_winner     (w_winner)
    );

    // Byte of the requester the arbiter is currently pointing at.
    always_comb begin
        w_sel_data = i_data[7:0];
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_winner == IDW'(k)) begin
                w_sel_data = i_data[8*k +: 8];
            end
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] r_wait_cnt;
    logic          r_timed_out;

    assign w_expire = (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Count cycles spent in WAIT and remember whether WAIT ended by expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt  <= '0;
            r_timed_out <= 1'b0;
        end else begin
            if (r_state == ST_LAUNCH) begin
                r_wait_cnt  <= '0;
                r_timed_out <= 1'b0;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt  <= r_wait_cnt + 1'b1;
                r_timed_out <= !i_tx_done && w_expire;
            end
        end
    end

    assign o_timeout = (r_state == ST_ACK) && r_timed_out;
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign w_expire             = 1'b0;
    assign o_timeout            = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state strobes; done is only honoured while in WAIT.
    always_comb begin
        w_next     = r_state;
        o_tx_start = 1'b0;
        o_ack      = '0;
        o_busy     = 1'b1;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (w_valid) begin
                    w_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                o_tx_start = 1'b1;
                w_next     = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done || w_expire) begin
                    w_next = ST_ACK;
                end
            end
            ST_ACK: begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    o_ack[k] = (r_grant_id == IDW'(k));
                end
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Latch the winner's byte and id at grant; rotate priority on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_data    <= 8'h00;
            r_grant_id   <= '0;
            r_last_grant <= IDW'(NUM_REQ - 1);
        end else begin
            if (r_state == ST_IDLE && w_valid) begin
                r_tx_data  <= w_sel_data;
                r_grant_id <= w_winner;
            end
            if (r_state == ST_ACK) begin
                r_last_grant <= r_grant_id;
            end
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_grant_id = r_grant_id;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed and randomized bench for uart_tx_sched
module tb_uart_tx_sched;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   i_req;
    logic [8*N-1:0] i_data;
    logic           i_tx_done;
    logic           o_tx_start;
    logic [7:0]     o_tx_data;
    logic [N-1:0]   o_ack;
    logic [1:0]     o_grant_id;
    logic           o_busy;
    logic           o_timeout;

    uart_tx_sched #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_data     (i_data),
        .i_tx_done  (i_tx_done),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .o_ack      (o_ack),
        .o_grant_id (o_grant_id),
        .o_busy     (o_busy),
        .o_timeout  (o_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [N-1:0] m_req;
    logic [7:0]   m_data [N];
    int           m_last;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".start"},   32'(o_tx_start), 0);
        chk({tag, ".ack"},     32'(o_ack),      0);
        chk({tag, ".timeout"}, 32'(o_timeout),  0);
        chk({tag, ".busy"},    32'(o_busy),     0);
        chk({tag, ".data"},    32'(o_tx_data),  0);
        chk({tag, ".grant"},   32'(o_grant_id), 0);
    endtask

    task automatic drive();
        i_req = m_req;
        for (int k = 0; k < N; k++) begin
            i_data[8*k +: 8] = m_data[k];
        end
    endtask

    // Reference: serve the first pending requester in the rotation that starts after the last one served.
    function automatic int model_pick(input logic [N-1:0] pend, input int last);
        int order[$];
        for (int off = 1; off <= N; off++) begin
            order.push_back((last + off) % N);
        end
        foreach (order[j]) begin
            if (pend[order[j]]) return order[j];
        end
        return -1;
    endfunction

    // One complete transfer, entered in IDLE with the request already driven.
    task automatic xfer(input int id, input int dly, input bit spur, input bit wd,
                        input logic [N-1:0] next_req, input string tag);
        logic [7:0]   b;
        logic [N-1:0] oh;
        b      = m_data[id];
        oh     = '0;
        oh[id] = 1'b1;
        tick();
        chk({tag, ".start"}, 32'(o_tx_start), 1);
        chk({tag, ".grant"}, 32'(o_grant_id), 32'(id));
        chk({tag, ".data"},  32'(o_tx_data),  32'(b));
        chk({tag, ".busy"},  32'(o_busy),     1);
        if (wd) m_req[id] = 1'b0;
        m_data[id] = 8'($urandom);
        drive();
        if (spur) i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        chk({tag, ".start_once"}, 32'(o_tx_start), 0);
        repeat (dly) tick();
        chk({tag, ".wait_ack"},  32'(o_ack),  0);
        chk({tag, ".wait_busy"}, 32'(o_busy), 1);
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        chk({tag, ".ack"},       32'(o_ack),      32'(oh));
        chk({tag, ".ack_data"},  32'(o_tx_data),  32'(b));
        chk({tag, ".ack_grant"}, 32'(o_grant_id), 32'(id));
        chk({tag, ".ack_to"},    32'(o_timeout),  0);
        m_req  = next_req;
        m_last = id;
        drive();
        tick();
        chk({tag, ".idle_busy"}, 32'(o_busy),    0);
        chk({tag, ".idle_ack"},  32'(o_ack),     0);
        chk({tag, ".idle_data"}, 32'(o_tx_data), 32'(b));
    endtask

    initial begin
        int           exp_rr [5];
        int           hit;
        logic         to_seen;
        logic [N-1:0] ack_seen;
        int           exp_id;
        logic [N-1:0] nxt;

        exp_rr = '{0, 1, 2, 3, 0};
        reset     = 1'b1;
        i_req     = '0;
        i_data    = '0;
        i_tx_done = 1'b0;
        m_req     = '0;
        m_last    = N - 1;
        for (int k = 0; k < N; k++) m_data[k] = 8'($urandom);

        #1;
        chk_reset("rst");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // all four held and re-raised: rotation 0,1,2,3,0
        m_req = '1;
        drive();
        for (int g = 0; g < 5; g++) begin
            xfer(exp_rr[g], 2 + g, 1'b0, 1'b0, (g < 4) ? '1 : '0, "rr");
        end

        // single requester, byte A5, done 20 cycles after start
        m_req     = 4'b0001;
        m_data[0] = 8'hA5;
        drive();
        xfer(0, 19, 1'b0, 1'b0, '0, "single");

        // requester 2 withdraws after grant
        m_req = 4'b0100;
        drive();
        xfer(2, 4, 1'b0, 1'b1, '0, "withdraw");

        // done in IDLE and in the LAUNCH cycle is ignored
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        chk("spur_idle.busy", 32'(o_busy), 0);
        chk("spur_idle.ack",  32'(o_ack),  0);
        m_req = 4'b0010;
        drive();
        xfer(1, 3, 1'b1, 1'b0, '0, "spur");

        // no done at all: timeout build aborts after 16 WAIT cycles, otherwise WAIT holds
        m_req = 4'b0001;
        drive();
        tick();
        chk("nodone.start", 32'(o_tx_start), 1);
        tick();
        hit      = 0;
        to_seen  = 1'b0;
        ack_seen = '0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (o_ack != '0 || o_timeout) begin
                hit      = k;
                to_seen  = o_timeout;
                ack_seen = o_ack;
                break;
            end
        end
`ifdef UART_TX_SCHED_TIMEOUT_EN
        chk("timeout.cycle", 32'(hit),      16);
        chk("timeout.pulse", 32'(to_seen),  1);
        chk("timeout.ack",   32'(ack_seen), 32'(4'b0001));
        m_req  = '0;
        m_last = 0;
        drive();
        tick();
        chk("timeout.idle", 32'(o_busy), 0);
        m_req = 4'b0001;
        drive();
        tick();
        tick();
        tick();
`else
        chk("nodone.hit",     32'(hit),       0);
        chk("nodone.busy",    32'(o_busy),    1);
        chk("nodone.timeout", 32'(o_timeout), 0);
`endif

        // reset while in WAIT clears everything at once and restores priority to 0
        #2 reset = 1'b1;
        #1;
        chk_reset("rst_wait");
        tick();
        chk_reset("rst_wait_hold");
        reset  = 1'b0;
        m_last = N - 1;
        m_req  = 4'b1001;
        drive();
        xfer(0, 2, 1'b0, 1'b0, 4'b1000, "rst_rr0");
        xfer(3, 1, 1'b0, 1'b0, 4'b0000, "rst_rr3");

        // randomized traffic against the rotation model
        for (int it = 0; it < 40; it++) begin
            if (m_req == '0) m_req = N'($urandom_range(1, 15));
            drive();
            exp_id = model_pick(m_req, m_last);
            nxt    = m_req;
            nxt[exp_id] = 1'b0;
            nxt    = nxt | (N'($urandom_range(0, 15)) & N'($urandom_range(0, 15)));
            xfer(exp_id, $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), nxt, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
